gfx_pixel_writer: RTL
=====================

Name: gfx_pixel_writer

Overview:
Downstream consumer of the line rasterizer's per-step (x, y) output. Accepts a stream of coordinates plus colour over a valid/ready handshake. Converts each in-bounds pixel to a linear framebuffer address and issues buffered write requests to the framebuffer memory port. Clips out-of-range pixels, signals end-of-primitive completion, and applies backpressure to the rasterizer through its enable.

Parameters:
FB_WIDTH, 640, framebuffer width in pixels
FB_HEIGHT, 480, framebuffer height in pixels
PIXEL_BITS, 12, colour/data width per pixel
FIFO_DEPTH, 4, write-request FIFO entries; power of two, minimum 4
(derived, not overridable) FB_X_BITS = $clog2(FB_WIDTH), FB_Y_BITS = $clog2(FB_HEIGHT), ADDR_BITS = $clog2(FB_WIDTH*FB_HEIGHT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  pixel offered
in_ready  out  1  pixel accepted when in_valid && in_ready at posedge
in_x  in  FB_X_BITS  pixel column
in_y  in  FB_Y_BITS  pixel row
in_color  in  PIXEL_BITS  pixel data
in_last  in  1  final pixel of the current primitive
mem_wr_valid  out  1  write request valid
mem_wr_ready  in  1  memory accepts request at posedge when both high
mem_wr_addr  out  ADDR_BITS  linear address y*FB_WIDTH + x
mem_wr_data  out  PIXEL_BITS  pixel data
frame_done  out  1  one-cycle pulse: last pixel of primitive retired
busy  out  1  any pixel in pipeline or FIFO
clip_count  out  16  saturating count of clipped pixels

Behaviour:
- Reset (synchronous, active-high): both pipeline stages invalid, FIFO empty, clip_count=0, frame_done=0, mem_wr_valid=0, busy=0. in_ready=0 while reset is high; it is 1 on the first cycle after reset deasserts. Reset mid-stream discards all in-flight and buffered pixels; no write is issued for them.
- Pipeline: stage A registers x, color, last, clip flag (x>=FB_WIDTH || y>=FB_HEIGHT), and product y*FB_WIDTH (ADDR_BITS wide, no truncation for in-range y). Stage B registers addr = product + x. Stage B output is pushed into the FIFO on the following edge.
- Latency: pixel accepted at edge N is pushed to the FIFO at edge N+2. mem_wr_valid is high in the cycle after N+2 when the FIFO was empty.
- Stages advance unconditionally; no stall inside the pipeline.
- Flow control: in_ready = (fifo_count + stageA_valid + stageB_valid) < FIFO_DEPTH. It is computed from registers only and is independent of in_valid and mem_wr_ready. The FIFO can never overflow. A same-cycle pop is not credited.
- Throughput: with mem_wr_ready held high and FIFO_DEPTH>=4, one pixel per cycle is sustained.
- FIFO: head drives mem_wr_addr/mem_wr_data. mem_wr_valid = non-empty && head is a write entry. Pop on mem handshake. Simultaneous push and pop leaves the count unchanged. Output values remain stable while mem_wr_valid=1 && mem_wr_ready=0.
- Clipping:
  - clipped pixel without last: dropped at stage B, never enters the FIFO.
  - clipped pixel with last: pushed as a marker entry (no write). At FIFO head the marker is popped in one cycle with mem_wr_valid=0.
  - clip_count increments per clipped pixel and saturates at 16'hFFFF.
- frame_done:
  - 1-cycle pulse on the cycle after a last-flagged write entry completes its mem handshake, or after a marker entry is popped.
  - Multiple primitives back to back each produce their own pulse, in order.
- busy = stageA_valid | stageB_valid | FIFO non-empty.
- Order: writes are issued in acceptance order; no reordering, no merging.
- Integration: rasterizer enable is tied to in_ready; its x, y feed in_x, in_y. in_valid is asserted during its DRAW state.

Test Plan:
- Reset release, single pixel x=5,y=2,color=12'hABC,last=1, mem_wr_ready=1 -> mem_wr_valid high 3 cycles after accept, addr=1285, data=12'hABC; frame_done pulses the cycle after the handshake; busy then 0.
- Corner pixels (0,0) and (639,479) -> addr 0 and 307199.
- mem_wr_ready=0, stream 10 pixels (0..9,0) -> exactly 4 accepted, then in_ready=0 with mem_wr_valid held and stable. Raise mem_wr_ready -> all 10 written in order, addr 0..9, no loss or duplication.
- Pixels (640,0,last=0), (3,480,last=1) -> no mem writes; clip_count=2; one frame_done pulse.
- Continuous 64-pixel stream with mem_wr_ready=1 -> in_ready never drops; one write per cycle; 64 writes.
- Assert reset with 3 pixels buffered and mem_wr_ready=0 -> after reset: mem_wr_valid=0, busy=0, clip_count=0, no frame_done; the next pixel behaves as in the first scenario.

Source files
------------

// File: rtl/gfx_pixel_writer.sv
// Pixel writer: turns rasterizer (x, y, colour) steps into linear framebuffer
// write requests through a two-stage address pipeline and a small request FIFO.
module gfx_pixel_writer #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int PIXEL_BITS = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int FB_X_BITS = $clog2(FB_WIDTH),
    localparam int FB_Y_BITS = $clog2(FB_HEIGHT),
    localparam int ADDR_BITS = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FB_X_BITS-1:0]  in_x,
    input  logic [FB_Y_BITS-1:0]  in_y,
    input  logic [PIXEL_BITS-1:0] in_color,
    input  logic                  in_last,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_BITS-1:0]  mem_wr_addr,
    output logic [PIXEL_BITS-1:0] mem_wr_data,
    output logic                  frame_done,
    output logic                  busy,
    output logic [15:0]           clip_count
);

    // Both handshakes complete on a rising edge where valid and ready are both
    // high; a producer holds its payload unchanged while valid is high and ready low.

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [FB_X_BITS:0] X_LIMIT = (FB_X_BITS + 1)'(FB_WIDTH);
    localparam logic [FB_Y_BITS:0] Y_LIMIT = (FB_Y_BITS + 1)'(FB_HEIGHT);
    localparam logic [CNT_BITS:0]  DEPTH_C = (CNT_BITS + 1)'(FIFO_DEPTH);

    logic                  accept;
    logic                  in_clip;

    logic                  a_valid;
    logic [FB_X_BITS-1:0]  a_x;
    logic [PIXEL_BITS-1:0] a_color;
    logic                  a_last;
    logic                  a_clip;
    logic [ADDR_BITS-1:0]  a_prod;

    logic                  b_valid;
    logic [ADDR_BITS-1:0]  b_addr;
    logic [PIXEL_BITS-1:0] b_color;
    logic                  b_last;
    logic                  b_clip;

    logic [ADDR_BITS-1:0]  f_addr  [FIFO_DEPTH];
    logic [PIXEL_BITS-1:0] f_data  [FIFO_DEPTH];
    logic                  f_last  [FIFO_DEPTH];
    logic                  f_write [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [CNT_BITS-1:0]   count;

    logic                  fifo_empty;
    logic                  head_write;
    logic                  head_last;
    logic                  push;
    logic                  pop;
    logic [CNT_BITS:0]     occupancy;

    // Credits count every pixel already committed downstream; a pop in the
    // same cycle is deliberately not credited so ready never depends on memory.
    always_comb begin
        occupancy = {1'b0, count} + (CNT_BITS + 1)'(a_valid) + (CNT_BITS + 1)'(b_valid);
        in_ready  = !reset && (occupancy < DEPTH_C);
        accept    = in_valid && in_ready;
        in_clip   = ({1'b0, in_x} >= X_LIMIT) || ({1'b0, in_y} >= Y_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            a_valid <= accept;
            b_valid <= a_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_x     <= in_x;
            a_color <= in_color;
            a_last  <= in_last;
            a_clip  <= in_clip;
            a_prod  <= ADDR_BITS'(in_y) * ADDR_BITS'(FB_WIDTH);
        end
        b_addr  <= a_prod + ADDR_BITS'(a_x);
        b_color <= a_color;
        b_last  <= a_last;
        b_clip  <= a_clip;
    end

    // A clipped pixel only occupies a slot when it carries the primitive's
    // last flag, so completion is still reported in order.
    always_comb begin
        fifo_empty   = (count == '0);
        head_write   = f_write[rd_ptr];
        head_last    = f_last[rd_ptr];
        push         = b_valid && (!b_clip || b_last);
        pop          = !fifo_empty && (!head_write || mem_wr_ready);
        mem_wr_valid = !fifo_empty && head_write;
        mem_wr_addr  = f_addr[rd_ptr];
        mem_wr_data  = f_data[rd_ptr];
        busy         = a_valid || b_valid || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr]  <= b_addr;
            f_data[wr_ptr]  <= b_color;
            f_last[wr_ptr]  <= b_last;
            f_write[wr_ptr] <= !b_clip;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            clip_count <= 16'd0;
        end else begin
            frame_done <= pop && head_last;
            if (a_valid && a_clip && (clip_count != 16'hFFFF)) begin
                clip_count <= clip_count + 16'd1;
            end
        end
    end

endmodule
